icache_pair_responder: RTL and testbench
========================================

Name: icache_pair_responder

Overview:
Instruction-side responder for the dual-issue fetch stage. Takes the fetch address each cycle and returns a 64-bit instruction pair: the word at the address and the word at address+4. Internally it is a direct-mapped, read-only cache. On a miss it stalls fetch and refills one line from memory through a valid/ack beat interface. It flags a pair that crosses a line boundary so fetch can consume a single instruction only.

Parameters:
LINE_WORDS, 8, 32-bit words per line (power of 2, >=2)
SETS, 64, number of lines (power of 2)

Ports:
clk  in  1  clock
reset  in  1  reset
req_addr  in  32  fetch address (bits [1:0] ignored)
inv  in  1  invalidate all lines (one-cycle pulse)
instr_pair  out  64  {word[addr+4], word[addr]}
single  out  1  only low word valid (addr is last word of line)
stall  out  1  lookup miss or refill in progress; fetch must hold req_addr
mem_req  out  1  refill request, held for whole burst
mem_addr  out  32  line base address of refill
mem_ack  in  1  one refill beat valid this cycle
mem_rdata  in  32  refill beat data, ascending word order

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Address split: offset = req_addr[2+OFF-1:2], where OFF = log2(LINE_WORDS). index = next log2(SETS) bits. tag = remaining upper bits.
- Lookup is combinational on req_addr. Hit = valid[index] && tag match, and only in IDLE.
- Hit, offset < LINE_WORDS-1: instr_pair = {line[offset+1], line[offset]}, single=0, stall=0.
- Hit, offset == LINE_WORDS-1: instr_pair = {32'h0, line[offset]}, single=1, stall=0. The next line is not checked.
- Miss, or any cycle in REFILL: stall=1, single=0, instr_pair=0.
- FSM states:
  - IDLE -> REFILL on a miss. At that edge, latch mem_addr = {req_addr[31:2+OFF], 0} and clear the beat counter.
  - REFILL: mem_req=1. Each cycle with mem_ack, write mem_rdata into line word[cnt] and increment cnt. cnt holds when mem_ack=0.
  - On the beat with cnt == LINE_WORDS-1: write the tag, set valid, return to IDLE at the same edge, and clear cnt.
- Miss latency: the miss is seen in cycle 0 and mem_req rises in cycle 1. With back-to-back acks, the hit returns in cycle LINE_WORDS+1, a minimum penalty of LINE_WORDS+1 cycles.
- mem_req is registered (decoded from state) and mem_addr is stable for the whole burst. mem_ack outside REFILL is ignored.
- inv in IDLE: clears all valid bits at the edge. A lookup in the same cycle uses the pre-clear state.
- inv in REFILL: latched as pending. Applied at the edge that completes the refill, so the new line ends invalid too. The next lookup misses and a new refill starts.
- Reset values: state IDLE, all valid=0, cnt=0, pending inv=0, mem_req=0, mem_addr=0. Outputs are therefore stall=1 (miss), single=0, instr_pair=0.
- Reset mid-refill: mem_req drops asynchronously and the partial line is never validated. The memory side must drop the burst.
- Data array contents are not reset.

Optional Feature:
ICACHE_PERF_EN. When defined, adds outputs hit_cnt[31:0] and miss_cnt[31:0], both saturating at 32'hFFFF_FFFF and reset to 0.
- hit_cnt increments on each IDLE cycle that hits.
- miss_cnt increments on each IDLE->REFILL transition.
When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package icache_pkg: the state enum (IDLE, REFILL), and OFF/INDEX/TAG width localparams derived from LINE_WORDS and SETS.
- One sub-module, icache_data_ram:
  - SETS*LINE_WORDS x 32 storage.
  - Two asynchronous read ports (word[offset], word[offset+1] within the same line).
  - One synchronous write port (index, cnt, data).
- Tag/valid arrays stay in the top module.

Test Plan:
1. Reset, then req_addr=0x0000_0000. Expect stall=1 and, one cycle later, mem_req=1 with mem_addr=0. Supply 8 beats 0x1000+i on consecutive cycles. Expect stall=0 in the cycle after the last beat, instr_pair=0x0000_1001_0000_1000, single=0.
2. Same line, req_addr=0x1C. Expect stall=0, instr_pair=0x0000_0000_0000_1007, single=1.
3. Conflict: req_addr=0x800 (index 0, tag 1) misses and refills with mem_addr=0x800. Then req_addr=0x0 misses again with mem_addr=0x0.
4. mem_ack asserted on alternate cycles only. Expect the counter to hold on gaps, the refill to complete after 16 cycles, and correct data at all offsets.
5. Assert reset after beat 3 of a refill. Expect mem_req=0 immediately. After release, req_addr=0x0 misses and the refill restarts from beat 0 with stall=1 throughout.
6. Pulse inv during REFILL. Expect the refill to complete with stall still 1, then a fresh refill of the same line. Pulse inv in IDLE after a hit; the next cycle, the same address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the dual-issue instruction cache responder.
//
// Contents:
//   state_t          - refill controller states (IDLE, REFILL)
//   DEF_LINE_WORDS   - default 32-bit words per cache line
//   DEF_SETS         - default number of direct-mapped lines
//   OFF_W            - offset field width for the default geometry
//   INDEX_W          - index field width for the default geometry
//   TAG_W            - tag field width for the default geometry
//   tag_width()      - tag width for any geometry (used by the top module)
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam int DEF_LINE_WORDS = 8;
    localparam int DEF_SETS       = 64;

    localparam int OFF_W   = $clog2(DEF_LINE_WORDS);
    localparam int INDEX_W = $clog2(DEF_SETS);
    localparam int TAG_W   = 32 - 2 - OFF_W - INDEX_W;

    // Byte offset (2 bits) + word offset + index; whatever remains is tag.
    function automatic int tag_width(input int line_words, input int sets);
        return 32 - 2 - $clog2(line_words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Data storage for the instruction cache: SETS lines of LINE_WORDS 32-bit words.
//
// Ports:
//   clk        in   clock (write port only)
//   rd_index   in   line selected for lookup
//   rd_offset  in   word within the line for the low instruction
//   rd_lo      out  word[rd_offset]            (asynchronous read)
//   rd_hi      out  word[rd_offset+1]          (asynchronous read, same line;
//                   wraps on the last word, caller masks that case)
//   we         in   write enable for one refill beat
//   wr_index   in   line being refilled
//   wr_offset  in   word within the line being written
//   wr_data    in   refill beat data
//
// Contents are deliberately not reset; the valid bits in the top module
// guard every read.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int SETS       = DEF_SETS,
    parameter int OFF        = $clog2(LINE_WORDS),
    parameter int IDX        = $clog2(SETS)
) (
    input  logic            clk,
    input  logic [IDX-1:0]  rd_index,
    input  logic [OFF-1:0]  rd_offset,
    output logic [31:0]     rd_lo,
    output logic [31:0]     rd_hi,
    input  logic            we,
    input  logic [IDX-1:0]  wr_index,
    input  logic [OFF-1:0]  wr_offset,
    input  logic [31:0]     wr_data
);

    logic [31:0]    mem [SETS*LINE_WORDS];
    logic [OFF-1:0] rd_offset_hi;

    // Wraps inside the line on purpose: the pair never straddles two lines.
    assign rd_offset_hi = rd_offset + 1'b1;

    assign rd_lo = mem[{rd_index, rd_offset}];
    assign rd_hi = mem[{rd_index, rd_offset_hi}];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_index, wr_offset}] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_pair_responder.sv
// Instruction-pair responder for the dual-issue fetch stage.
// Direct-mapped, read-only cache returning {word[addr+4], word[addr]} each
// cycle; on a miss it stalls fetch and refills one line through a
// valid/ack beat interface.
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   req_addr    in   fetch address (bits [1:0] ignored)
//   inv         in   invalidate all lines (one-cycle pulse)
//   instr_pair  out  {word[addr+4], word[addr]}
//   single      out  only the low word is valid (last word of line)
//   stall       out  lookup miss or refill in progress
//   mem_req     out  refill request, held for the whole burst
//   mem_addr    out  line base address of the refill
//   mem_ack     in   one refill beat valid this cycle
//   mem_rdata   in   refill beat data, ascending word order
//   hit_cnt     out  saturating hit counter      (ICACHE_PERF_EN only)
//   miss_cnt    out  saturating miss counter     (ICACHE_PERF_EN only)
//
// Build option: define ICACHE_PERF_EN to add the hit/miss counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | lookups served; a miss latches the line address and starts a refill
// REFILL | mem_req high; each mem_ack writes one word, last beat returns to IDLE
module icache_pair_responder
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int SETS       = DEF_SETS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_addr,
    input  logic        inv,
    output logic [63:0] instr_pair,
    output logic        single,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF  = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = tag_width(LINE_WORDS, SETS);

    localparam logic [OFF-1:0] LAST_OFF = OFF'(LINE_WORDS - 1);

    state_t state_q, state_d;

    logic [OFF-1:0]  offset;
    logic [IDX-1:0]  index;
    logic [TAGW-1:0] tag;

    logic [IDX-1:0]  refill_index;
    logic [TAGW-1:0] refill_tag;

    logic [TAGW-1:0] tag_arr [SETS];
    logic [SETS-1:0] valid_q;
    logic [OFF-1:0]  cnt_q;
    logic            inv_pend_q;
    logic            mem_req_q;
    logic [31:0]     mem_addr_q;

    logic [31:0]     rd_lo, rd_hi;
    logic            hit;
    logic            start_refill;
    logic            beat_we;
    logic            last_beat;

    // Byte-lane bits and the zeroed low bits of the line address carry no state.
    logic            unused_bits;
    assign unused_bits = ^{req_addr[1:0], mem_addr_q[1+OFF:0]};

    assign offset = req_addr[2 +: OFF];
    assign index  = req_addr[2+OFF +: IDX];
    assign tag    = req_addr[31 -: TAGW];

    // The line being refilled is identified by the latched mem_addr, so
    // fetch is free to present anything while stalled without corrupting it.
    assign refill_index = mem_addr_q[2+OFF +: IDX];
    assign refill_tag   = mem_addr_q[31 -: TAGW];

    assign hit          = (state_q == IDLE) && valid_q[index] && (tag_arr[index] == tag);
    assign start_refill = (state_q == IDLE) && !hit;
    assign beat_we      = (state_q == REFILL) && mem_ack;
    assign last_beat    = beat_we && (cnt_q == LAST_OFF);

    icache_data_ram #(
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS),
        .OFF        (OFF),
        .IDX        (IDX)
    ) u_data_ram (
        .clk        (clk),
        .rd_index   (index),
        .rd_offset  (offset),
        .rd_lo      (rd_lo),
        .rd_hi      (rd_hi),
        .we         (beat_we),
        .wr_index   (refill_index),
        .wr_offset  (cnt_q),
        .wr_data    (mem_rdata)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_refill) state_d = REFILL;
            REFILL:  if (last_beat)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: lookup outputs
    always_comb begin
        stall      = 1'b1;
        single     = 1'b0;
        instr_pair = 64'h0;
        if (hit) begin
            stall = 1'b0;
            if (offset == LAST_OFF) begin
                single     = 1'b1;
                instr_pair = {32'h0, rd_lo};
            end else begin
                instr_pair = {rd_hi, rd_lo};
            end
        end
    end

    // mem_req comes straight from a flop so the memory side sees a clean level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_q <= 1'b0;
        end else begin
            mem_req_q <= (state_d == REFILL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_q <= 32'h0;
            cnt_q      <= '0;
        end else begin
            if (start_refill) begin
                mem_addr_q <= {req_addr[31:2+OFF], {(2+OFF){1'b0}}};
                cnt_q      <= '0;
            end else if (last_beat) begin
                cnt_q <= '0;
            end else if (beat_we) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // An inv seen during a refill is held and applied when the line
    // completes, so the freshly filled line is born invalid as well.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (inv) valid_q <= '0;
            end else begin
                if (last_beat) begin
                    valid_q[refill_index] <= !(inv_pend_q || inv);
                    inv_pend_q            <= 1'b0;
                end else if (inv) begin
                    inv_pend_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (last_beat) begin
            tag_arr[refill_index] <= refill_tag;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if (hit && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_refill && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_pair_responder.sv
// Directed self-checking bench for icache_pair_responder (default build,
// LINE_WORDS=8, SETS=64). Inputs change 2 time units after a rising edge,
// outputs are checked before the next edge.
module tb_icache_pair_responder;

    logic        clk;
    logic        reset;
    logic [31:0] req_addr;
    logic        inv;
    logic [63:0] instr_pair;
    logic        single;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    icache_pair_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_addr   (req_addr),
        .inv        (inv),
        .instr_pair (instr_pair),
        .single     (single),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in the cycle the miss is visible; runs a full back-to-back burst.
    task automatic refill_burst(input string tag, input logic [31:0] exp_addr,
                                input logic [31:0] dbase);
        chk({tag, "_miss_stall"}, 64'(stall), 64'd1);
        tick();
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd1);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        for (int i = 0; i < 8; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = dbase + 32'(i);
            look();
            chk({tag, "_refill_stall"}, 64'(stall), 64'd1);
            tick();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        look();
        chk({tag, "_done_stall"}, 64'(stall), 64'd0);
        chk({tag, "_done_req"}, 64'(mem_req), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_addr  = 32'h0;
        inv       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) tick();
        chk("rst_stall", 64'(stall), 64'd1);
        chk("rst_single", 64'(single), 64'd0);
        chk("rst_pair", instr_pair, 64'h0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);

        // 1: cold miss on line 0
        reset = 1'b0;
        look();
        chk("t1_req_before", 64'(mem_req), 64'd0);
        refill_burst("t1", 32'h0, 32'h1000);
        chk("t1_pair", instr_pair, 64'h0000_1001_0000_1000);
        chk("t1_single", 64'(single), 64'd0);

        // 2: same line, last word and neighbour
        req_addr = 32'h1C;
        look();
        chk("t2_stall", 64'(stall), 64'd0);
        chk("t2_pair_last", instr_pair, 64'h0000_0000_0000_1007);
        chk("t2_single_last", 64'(single), 64'd1);
        req_addr = 32'h18;
        look();
        chk("t2_pair_6", instr_pair, 64'h0000_1007_0000_1006);
        chk("t2_single_6", 64'(single), 64'd0);

        // 3: conflict on index 0
        req_addr = 32'h800;
        look();
        refill_burst("t3a", 32'h800, 32'h2000);
        req_addr = 32'h804;
        look();
        chk("t3_pair_804", instr_pair, 64'h0000_2002_0000_2001);
        req_addr = 32'h0;
        look();
        refill_burst("t3b", 32'h0, 32'h1000);
        chk("t3_pair_0", instr_pair, 64'h0000_1001_0000_1000);

        // 4: acks on alternate cycles, line at 0x20
        req_addr = 32'h20;
        look();
        chk("t4_miss", 64'(stall), 64'd1);
        tick();
        chk("t4_mem_addr", 64'(mem_addr), 64'h20);
        for (int i = 0; i < 8; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h3000 + 32'(i);
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_0000 + 32'(i);
            look();
            if (i < 7) begin
                chk("t4_gap_stall", 64'(stall), 64'd1);
                tick();
            end
        end
        chk("t4_done_stall", 64'(stall), 64'd0);
        for (int o = 0; o < 8; o++) begin
            req_addr = 32'h20 + 32'(4 * o);
            look();
            if (o < 7) begin
                chk("t4_pair", instr_pair, {32'h3001 + 32'(o), 32'h3000 + 32'(o)});
                chk("t4_single", 64'(single), 64'd0);
            end else begin
                chk("t4_pair_last", instr_pair, {32'h0, 32'h3007});
                chk("t4_single_last", 64'(single), 64'd1);
            end
        end
        // stray ack in IDLE must not touch the line
        req_addr  = 32'h20;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        tick();
        mem_ack = 1'b0;
        look();
        chk("t4_stray_ack", instr_pair, 64'h0000_3001_0000_3000);

        // 5: reset after beat 3 of a refill
        req_addr = 32'h40;
        look();
        chk("t5_miss", 64'(stall), 64'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h7700 + 32'(i);
            tick();
        end
        mem_ack = 1'b0;
        reset   = 1'b1;
        look();
        chk("t5_req_async_drop", 64'(mem_req), 64'd0);
        chk("t5_addr_reset", 64'(mem_addr), 64'd0);
        tick();
        reset    = 1'b0;
        req_addr = 32'h0;
        look();
        refill_burst("t5", 32'h0, 32'h4000);
        chk("t5_pair_0", instr_pair, 64'h0000_4001_0000_4000);
        req_addr = 32'h1C;
        look();
        chk("t5_pair_last", instr_pair, 64'h0000_0000_0000_4007);
        req_addr = 32'h40;
        look();
        chk("t5_partial_invalid", 64'(stall), 64'd1);
        tick();
        chk("t5_partial_req", 64'(mem_req), 64'd1);
        chk("t5_partial_addr", 64'(mem_addr), 64'h40);
        for (int i = 0; i < 8; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h7700 + 32'(i);
            tick();
        end
        mem_ack = 1'b0;

        // 6: inv during REFILL, then inv in IDLE
        req_addr = 32'h60;
        look();
        chk("t6_miss", 64'(stall), 64'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h5500 + 32'(i);
            inv       = (i == 2);
            tick();
        end
        mem_ack = 1'b0;
        inv     = 1'b0;
        look();
        chk("t6_still_stall", 64'(stall), 64'd1);
        chk("t6_idle_req", 64'(mem_req), 64'd0);
        refill_burst("t6", 32'h60, 32'h5000);
        chk("t6_pair", instr_pair, 64'h0000_5001_0000_5000);
        inv = 1'b1;
        look();
        chk("t6_inv_same_cycle_hit", 64'(stall), 64'd0);
        chk("t6_inv_same_cycle_pair", instr_pair, 64'h0000_5001_0000_5000);
        tick();
        inv = 1'b0;
        look();
        chk("t6_after_inv_miss", 64'(stall), 64'd1);
        chk("t6_after_inv_pair", instr_pair, 64'h0);
        tick();
        chk("t6_after_inv_req", 64'(mem_req), 64'd1);
        chk("t6_after_inv_addr", 64'(mem_addr), 64'h60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
